serial_framer: RTL

Parallel-to-serial framer that feeds the serial-input shift register stage. It accepts a WIDTH-bit word over a valid/ready handshake and transmits it on a single-bit line as a framed sequence: start bit, data MSB-first, optional even parity, stop bit. Each bit is held for CLKS_PER_BIT cycles, so the downstream shift register can sample it at a fixed rate.

---
 rtl/serial_framer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/serial_framer.sv
// -----------------------------------------------------------------------------
// serial_framer
//
// Parallel-to-serial framer feeding a serial-input shift register stage.
// A WIDTH-bit word is accepted over a valid/ready handshake. It is sent on a
// single line as a frame: start bit (0), data MSB first, an optional even
// parity bit, and a stop bit (1). Each bit is held for CLKS_PER_BIT cycles.
//
// Parameters
//   WIDTH        data word width (>= 1)
//   CLKS_PER_BIT cycles each serial bit is held (>= 1)
//   PARITY_EN    1 inserts an even-parity bit after the data, 0 omits it
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   din_data   word to transmit, captured on the handshake edge
//   din_valid  upstream has a word available
//   din_ready  framer can accept a word this cycle (IDLE or final STOP cycle)
//   dout       serial line, idles high
//   busy       a frame is in progress
//   done       one-cycle pulse in the final cycle of a frame
//
// All outputs are registered. Their next values are computed together with
// the next state, so every output already matches the state it belongs to.
// -----------------------------------------------------------------------------
module serial_framer #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_data,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
    // With a one-cycle bit, entering STOP also means entering its final cycle.
    localparam logic          STOP_ONE = (CLKS_PER_BIT == 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Even parity: the parity bit makes the total number of ones even.
    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] shift_r;
    logic             parity_r;
    logic [CW-1:0]    cnt_r;
    logic [IW-1:0]    idx_r;
    logic             dout_r;
    logic             busy_r;
    logic             done_r;
    logic             ready_r;

    logic             cnt_last_s;
    logic [CW-1:0]    cnt_inc_s;
    logic             stop_final_next_s;
    logic             accept_s;
    logic [WIDTH-1:0] shift_shl_s;

    // Helper terms shared by the FSM.
    always_comb begin
        cnt_last_s        = (cnt_r == CNT_LAST);
        cnt_inc_s         = cnt_r + CW'(1);
        // Only consulted while not in the last cycle, so cnt_inc_s cannot wrap.
        stop_final_next_s = (cnt_inc_s == CNT_LAST);
        accept_s          = din_valid & ready_r;
        shift_shl_s       = shift_r << 1;
    end

    // Frame sequencer: state, counters, captured word and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            shift_r  <= '0;
            parity_r <= 1'b0;
            cnt_r    <= '0;
            idx_r    <= '0;
            dout_r   <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ready_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r  <= ST_START;
                        shift_r  <= din_data;
                        parity_r <= even_parity(din_data);
                        cnt_r    <= '0;
                        idx_r    <= '0;
                        dout_r   <= 1'b0;
                        busy_r   <= 1'b1;
                        done_r   <= 1'b0;
                        ready_r  <= 1'b0;
                    end else begin
                        dout_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b0;
                        ready_r  <= 1'b1;
                    end
                end

                ST_START: begin
                    busy_r  <= 1'b1;
                    done_r  <= 1'b0;
                    ready_r <= 1'b0;
                    if (cnt_last_s) begin
                        state_r <= ST_DATA;
                        cnt_r   <= '0;
                        idx_r   <= '0;
                        dout_r  <= shift_r[WIDTH-1];
                    end else begin
                        cnt_r   <= cnt_inc_s;
                        dout_r  <= 1'b0;
                    end
                end

                ST_DATA: begin
                    busy_r <= 1'b1;
                    if (cnt_last_s) begin
                        cnt_r <= '0;
                        if (idx_r == IDX_LAST) begin
                            if (PARITY_EN != 0) begin
                                state_r <= ST_PARITY;
                                dout_r  <= parity_r;
                                done_r  <= 1'b0;
                                ready_r <= 1'b0;
                            end else begin
                                state_r <= ST_STOP;
                                dout_r  <= 1'b1;
                                done_r  <= STOP_ONE;
                                ready_r <= STOP_ONE;
                            end
                        end else begin
                            // Next data bit: shift the captured word toward the MSB.
                            idx_r   <= idx_r + IW'(1);
                            shift_r <= shift_shl_s;
                            dout_r  <= shift_shl_s[WIDTH-1];
                            done_r  <= 1'b0;
                            ready_r <= 1'b0;
                        end
                    end else begin
                        cnt_r   <= cnt_inc_s;
                        dout_r  <= shift_r[WIDTH-1];
                        done_r  <= 1'b0;
                        ready_r <= 1'b0;
                    end
                end

                ST_PARITY: begin
                    busy_r <= 1'b1;
                    if (cnt_last_s) begin
                        state_r <= ST_STOP;
                        cnt_r   <= '0;
                        dout_r  <= 1'b1;
                        done_r  <= STOP_ONE;
                        ready_r <= STOP_ONE;
                    end else begin
                        cnt_r   <= cnt_inc_s;
                        dout_r  <= parity_r;
                        done_r  <= 1'b0;
                        ready_r <= 1'b0;
                    end
                end

                ST_STOP: begin
                    if (cnt_last_s) begin
                        cnt_r <= '0;
                        if (accept_s) begin
                            // Back-to-back: the next start bit follows immediately.
                            state_r  <= ST_START;
                            shift_r  <= din_data;
                            parity_r <= even_parity(din_data);
                            idx_r    <= '0;
                            dout_r   <= 1'b0;
                            busy_r   <= 1'b1;
                            done_r   <= 1'b0;
                            ready_r  <= 1'b0;
                        end else begin
                            state_r  <= ST_IDLE;
                            dout_r   <= 1'b1;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b0;
                            ready_r  <= 1'b1;
                        end
                    end else begin
                        cnt_r   <= cnt_inc_s;
                        dout_r  <= 1'b1;
                        busy_r  <= 1'b1;
                        // Final STOP cycle is next: raise done and ready with it.
                        done_r  <= stop_final_next_s;
                        ready_r <= stop_final_next_s;
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    idx_r   <= '0;
                    dout_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign din_ready = ready_r;
    assign dout      = dout_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule
